// File: rtl/bitwise_operand_loader.sv
// Serial-to-parallel loader: shifts in operand X then operand Y (LSB first) and
// presents them as held parallel buses to the bitwise AND stage with valid/ready.
module bitwise_operand_loader #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_X,
      S_LOAD_Y,
      S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [WIDTH-1:0] r_xs;
   logic [WIDTH-1:0] r_ys;
   logic [WIDTH-1:0] w_xs_next;
   logic [WIDTH-1:0] w_ys_next;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_err;
   logic             w_abort;
   logic             w_commit;
   logic             w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A start seen while loading takes priority over any data bit, including the last one.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_xs_next  = r_xs;
      w_ys_next  = r_ys;
      w_abort    = 1'b0;
      w_commit   = 1'b0;
      w_last     = (r_cnt == LAST);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next     = S_LOAD_X;
               w_cnt_next = '0;
               w_xs_next  = '0;
               w_ys_next  = '0;
            end
         end
         S_LOAD_X: begin
            if (start) begin
               w_abort    = 1'b1;
               w_next     = S_LOAD_X;
               w_cnt_next = '0;
               w_xs_next  = '0;
               w_ys_next  = '0;
            end else if (sin_valid) begin
               w_xs_next[r_cnt] = sin;
               if (w_last) begin
                  w_next     = S_LOAD_Y;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_LOAD_Y: begin
            if (start) begin
               w_abort    = 1'b1;
               w_next     = S_LOAD_X;
               w_cnt_next = '0;
               w_xs_next  = '0;
               w_ys_next  = '0;
            end else if (sin_valid) begin
               w_ys_next[r_cnt] = sin;
               if (w_last) begin
                  w_next     = S_HOLD;
                  w_commit   = 1'b1;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_xs        <= '0;
         r_ys        <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_xs  <= w_xs_next;
         r_ys  <= w_ys_next;
         // Output operands only move when a complete pair lands, so the AND stage never sees partials.
         if (w_commit) begin
            r_x <= w_xs_next;
            r_y <= w_ys_next;
         end
         r_out_valid <= (w_next == S_HOLD);
         r_busy      <= (w_next == S_LOAD_X) || (w_next == S_LOAD_Y);
         r_err       <= w_abort;
      end
   end

   assign x         = r_x;
   assign y         = r_y;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: doc/bitwise_operand_loader.md
Name: bitwise_operand_loader

Overview:
Serial-to-parallel operand loader that sits directly upstream of the 4-bit bitwise AND stage. It receives operand bits one at a time from a single-bit input. It assembles operand X, then operand Y, and presents both as held parallel buses with a valid/ready handshake. The downstream stage ANDs them bit by bit (x[i] drives the AND stage's xi input, y[i] drives its yi input).

Parameters:
WIDTH, 4, bits per operand (x and y each WIDTH bits; matches the 4-bit AND stage)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start; begins (or restarts) loading of a new operand pair
sin  input  1  serial data bit
sin_valid  input  1  sin carries a valid bit this cycle
x  output  WIDTH  operand X to the AND stage (x[0] -> x0 ... x[3] -> x3)
y  output  WIDTH  operand Y to the AND stage (y[0] -> y0 ... y[3] -> y3)
out_valid  output  1  x/y hold a complete, unconsumed operand pair
out_ready  input  1  downstream accepts the pair
busy  output  1  loader is mid-frame (LOAD_X or LOAD_Y)
err  output  1  one-cycle pulse: frame aborted by start during loading

Behaviour:
- Reset: asynchronous, active-low; takes effect immediately on rst_n=0, independent of clk.
  - While reset is asserted: state=IDLE, bit counter=0, shift registers=0, x=0, y=0, out_valid=0, busy=0, err=0.
  - Reset asserted mid-frame or in HOLD discards everything.
- All other state changes occur on the rising edge of clk. All outputs are registered.
- Bit counter: width clog2(WIDTH); counts 0..WIDTH-1.
- Bit order: LSB first; the bit at counter value k goes to bit k of the operand being loaded.
- States:
  - IDLE:
    - start=1 -> LOAD_X, counter=0.
    - sin/sin_valid are ignored in IDLE, including on the start cycle (the start cycle carries no data).
  - LOAD_X:
    - Each cycle with sin_valid=1: xs[counter] <= sin, counter++.
    - On the WIDTH-th valid bit -> LOAD_Y, counter=0.
    - sin_valid=0: hold; no timeout.
  - LOAD_Y:
    - Same as LOAD_X, writing ys.
    - On the WIDTH-th valid bit -> HOLD. On that same edge: x <= xs, y <= ys including the bit arriving that cycle, and out_valid <= 1.
  - HOLD:
    - out_valid=1.
    - out_valid&out_ready -> IDLE; out_valid=0 from the next cycle.
    - sin_valid is ignored.
- x/y update only on the LOAD_Y->HOLD transition. They retain their last values in IDLE and during subsequent loads, so the AND stage sees stable operands.
- busy=1 exactly in LOAD_X and LOAD_Y.
- Latency: out_valid rises on the edge that samples the 2*WIDTH-th valid bit. Minimum frame is 1 start cycle + 2*WIDTH bit cycles.
- Boundary cases:
  - start=1 in LOAD_X or LOAD_Y: abort the frame. err=1 for exactly one cycle, partial xs/ys are discarded, next state=LOAD_X with counter=0. Any sin on that cycle is ignored.
  - start=1 together with the final valid bit of LOAD_Y: start wins. The frame is aborted with err, there is no transfer to HOLD, and x/y are unchanged.
  - start=1 in HOLD: ignored. The pending pair must be consumed first; no err.
  - start=1 in HOLD in the same cycle as out_ready=1: accept only, go to IDLE; start is not latched.
  - out_ready in IDLE/LOAD states: ignored.
  - Back-to-back: after acceptance, a new start is honoured one cycle later, from IDLE.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-LOAD_Y (between clock edges) -> x=0, y=0, out_valid=0, busy=0, err=0 immediately; state IDLE after release.
- Normal frame: start, then sin_valid=1 with bits 1,0,1,1 (X) and 1,1,0,0 (Y), out_ready=0 -> out_valid=1 on the 8th data edge, x=4'b1101, y=4'b0011; both stable for 5 cycles, then out_ready=1 -> out_valid=0 next cycle, x/y retained.
- Gapped input: same frame with sin_valid=0 inserted after every bit -> identical x/y; busy=1 throughout loading; out_valid only after the 8th valid bit.
- Abort: start, 3 X bits, then start again, then a full frame giving x=4'b0110, y=4'b1010 -> err pulses for 1 cycle at the second start; final x=4'b0110, y=4'b1010, no trace of the partial bits.
- Start ignored in HOLD: a pair is pending with out_ready=0; pulse start plus 4 sin bits -> no err, x/y unchanged, still HOLD. Then out_ready=1 with start=1 in the same cycle -> IDLE, no new frame started.
- Final-bit collision: assert start together with the 8th valid bit -> err=1, out_valid stays 0, x/y keep the previous pair, busy=1 in LOAD_X.
